lsu_axi_wr: RTL
===============

Name: lsu_axi_wr

Overview:
- AXI-lite write master between the LSU store path and the peripheral/memory slaves (UART, SRAM).
- Accepts one store request on a simple valid/ready port and drives the AW, W and B channels.
- Issues AW and W together and completes each independently.
- Returns the write response to the LSU as a one-cycle pulse, with a watchdog on the B channel.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, write data width; strobe width is DATA_W/8.
- B_TIMEOUT, 255, max cycles spent in WAIT_B before the transaction is abandoned (1..65535).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  LSU store request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_addr_i  in  ADDR_W  store address.
- req_data_i  in  DATA_W  store data.
- req_strb_i  in  DATA_W/8  byte strobes.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_o  out  2  completion code: bresp, or 2'b11 on timeout.
- timeout_o  out  1  high with resp_valid_o when the completion is a timeout.
- awaddr_o  out  ADDR_W  AXI write address.
- awvalid_o  out  1
- awready_i  in  1
- wdata_o  out  DATA_W
- wstrb_o  out  DATA_W/8
- wvalid_o  out  1
- wready_i  in  1
- bresp_i  in  2
- bvalid_i  in  1
- bready_o  out  1

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all outputs 0, payload registers 0, timer 0. Reset mid-transaction aborts immediately with no response pulse.
- States:
  - IDLE: req_ready_o=1. On request handshake, latch addr/data/strb, set aw_pend=w_pend=1, go to SEND.
  - SEND: awvalid_o=aw_pend and wvalid_o=w_pend.
    - aw_pend clears on the AW handshake; w_pend clears on the W handshake. Either may happen first, or both in the same cycle.
    - When both are clear (or clearing this cycle), go to WAIT_B. Timer is 0.
  - WAIT_B: bready_o=1. Timer increments each cycle.
    - On bvalid_i, register bresp_i into resp_o, timeout_o=0, go to DONE.
    - If the timer reaches B_TIMEOUT-1 with no bvalid_i, set resp_o=2'b11, timeout_o=1, go to DONE. bvalid_i in the same cycle wins over the timeout.
  - DONE: resp_valid_o=1 for exactly this cycle, then go to IDLE. req_ready_o=0.
- Handshake rules:
  - awvalid_o/wvalid_o, once high, stay high with stable payload until their own handshake. They never depend combinationally on the ready inputs.
  - awaddr_o/wdata_o/wstrb_o hold the latched payload from accept until the next accept.
- Ordering and capacity:
  - Exactly one outstanding transaction. req_ready_o is low in SEND, WAIT_B and DONE.
  - A held request is accepted in the first IDLE cycle.
- Latency:
  - Request accepted in cycle N; awvalid_o/wvalid_o high from N+1.
  - With zero-wait slave readies, both handshakes occur at N+1 and WAIT_B starts at N+2.
  - resp_valid_o appears the cycle after the B handshake.
  - Minimum request-to-request spacing is 4 cycles.
- Protocol exceptions:
  - bvalid_i outside WAIT_B is ignored (bready_o=0).
  - Timeout abandons only B. AW and W have already completed.

Test Plan:
1. UART-like slave (ready when idle, bvalid 2 cycles after W, bresp=0): req addr 0xa00003f8, data 0x41, strb 0x01 accepted at cycle 0 -> AW and W handshake at cycle 1; bready/bvalid at 3; resp_valid_o=1, resp_o=0, timeout_o=0 at cycle 4 only.
2. awready_i held low 3 cycles, wready_i immediate -> wvalid_o drops after cycle 1; awvalid_o stays high with stable awaddr_o through cycle 4; B accepted only after both complete.
3. Slave never asserts bvalid, B_TIMEOUT=8 -> resp_valid_o pulses 8 cycles after WAIT_B entry with resp_o=2'b11, timeout_o=1; a later bvalid_i is ignored.
4. Slave returns bresp=2'b10 -> resp_o=2'b10 with the pulse.
5. Back-to-back req_valid_i held high, data 0x41 then 0x42, zero-wait slave -> second accept exactly 4 cycles after the first; wdata_o changes only at the second accept.
6. rst asserted while in SEND -> all valids and bready_o drop asynchronously, no resp_valid_o, req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_axi_wr.sv
`default_nettype none
// ============================================================================
// Module      : lsu_axi_wr
// Description : AXI-lite write master for the LSU store path. Takes one store
//               at a time, issues AW and W together, then waits on B with a
//               watchdog and returns a one-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi_wr #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int B_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_strb_i,

    output logic                resp_valid_o,
    output logic [1:0]          resp_o,
    output logic                timeout_o,

    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o
);

    localparam int STRB_W = DATA_W / 8;

    // Out-of-range timeouts are clamped into the 16-bit timer range.
    localparam int          C_TMO_CLAMP = (B_TIMEOUT < 1)     ? 1     :
                                          (B_TIMEOUT > 65535) ? 65535 : B_TIMEOUT;
    localparam logic [15:0] C_TMO_LAST  = 16'(C_TMO_CLAMP - 1);
    localparam logic [1:0]  C_RESP_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_WAIT_B = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_aw_pend;
    logic                r_w_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [STRB_W-1:0]   r_strb;
    logic [15:0]         r_timer;
    logic [1:0]          r_resp;
    logic                r_timeout;

    logic                w_accept;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_tmo;
    logic                w_aw_clear;
    logic                w_w_clear;

    // Channel valids are pure state decodes so they never follow the readies.
    assign awvalid_o    = (r_state == S_SEND) && r_aw_pend;
    assign wvalid_o     = (r_state == S_SEND) && r_w_pend;
    assign bready_o     = (r_state == S_WAIT_B);
    assign resp_valid_o = (r_state == S_DONE);
    // Gated by the reset pin so ready is low while reset is held.
    assign req_ready_o  = (r_state == S_IDLE) && rst;

    assign awaddr_o     = r_addr;
    assign wdata_o      = r_data;
    assign wstrb_o      = r_strb;
    assign resp_o       = r_resp;
    assign timeout_o    = r_timeout;

    assign w_accept     = (r_state == S_IDLE) && req_valid_i;
    assign w_aw_hs      = awvalid_o && awready_i;
    assign w_w_hs       = wvalid_o && wready_i;
    assign w_b_hs       = bready_o && bvalid_i;
    assign w_tmo        = bready_o && !bvalid_i && (r_timer == C_TMO_LAST);
    assign w_aw_clear   = !r_aw_pend || w_aw_hs;
    assign w_w_clear    = !r_w_pend || w_w_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_aw_clear && w_w_clear) begin
                    w_state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (bvalid_i || (r_timer == C_TMO_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Payload is captured on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (w_accept) begin
            r_addr <= req_addr_i;
            r_data <= req_data_i;
            r_strb <= req_strb_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else if (w_accept) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
        end else begin
            if (w_aw_hs) begin
                r_aw_pend <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_pend <= 1'b0;
            end
        end
    end

    // Timer runs only while waiting on B and is zero on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT_B) begin
            r_timer <= r_timer + 16'd1;
        end else begin
            r_timer <= '0;
        end
    end

    // A B beat in the final timer cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp    <= 2'b00;
            r_timeout <= 1'b0;
        end else if (w_b_hs) begin
            r_resp    <= bresp_i;
            r_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_resp    <= C_RESP_TMO;
            r_timeout <= 1'b1;
        end
    end

endmodule
`default_nettype wire
